// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the RV32I pipeline hazard controller: FSM state,
// register-index width and the bundle of stage-register load/flush enables.
package hazard_stall_unit_pkg;

   localparam int REG_W = 5;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazard_state_t;

   typedef struct packed {
      logic pc_load;
      logic if_id_load;
      logic id_ex_load;
      logic ex_mem_load;
      logic mem_wb_load;
      logic if_id_flush;
      logic id_ex_flush;
   } pipe_ctrl_t;

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The slave modport is the controller's view; master is the datapath's view.
interface hazard_stall_unit_if #(
   parameter int CNT_W = 32
);
   logic [hazard_stall_unit_pkg::REG_W-1:0] id_rs1;
   logic [hazard_stall_unit_pkg::REG_W-1:0] id_rs2;
   logic                                    id_uses_rs1;
   logic                                    id_uses_rs2;
   logic                                    ex_mem_read;
   logic [hazard_stall_unit_pkg::REG_W-1:0] ex_rd;
   logic                                    ex_br_taken;
   logic                                    icache_read;
   logic                                    icache_resp;
   logic                                    dcache_req;
   logic                                    dcache_resp;

   logic             pc_load;
   logic             if_id_load;
   logic             id_ex_load;
   logic             ex_mem_load;
   logic             mem_wb_load;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] bubble_count;
   logic [CNT_W-1:0] flush_count;
   logic             stall_timeout;

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
             ex_br_taken, icache_read, icache_resp, dcache_req, dcache_resp,
      output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
             if_id_flush, id_ex_flush, stall_count, bubble_count, flush_count,
             stall_timeout
   );

   modport master (
      output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
             ex_br_taken, icache_read, icache_resp, dcache_req, dcache_resp,
      input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
             if_id_flush, id_ex_flush, stall_count, bubble_count, flush_count,
             stall_timeout
   );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage RV32I core: memory freeze, load-use bubble
// and taken-branch flush, plus saturating event counters and a stall watchdog.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input logic                 clk,
   input logic                 reset,
   hazard_stall_unit_if.slave  bus
);

   localparam int RUN_W = $clog2(TIMEOUT + 1);

   logic          mem_stall;
   logic          load_use;
   pipe_ctrl_t    ctrl;
   logic          stall_inc;
   logic          bubble_inc;
   logic          flush_inc;

   hazard_state_t state_q, state_d;
   logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
   logic          stall_timeout_q, stall_timeout_d;

   // A frozen pipeline keeps EX and ID intact, so branch/load-use are simply
   // re-evaluated on the advance cycle rather than remembered.
   always_comb begin
      mem_stall  = (bus.icache_read & ~bus.icache_resp) |
                   (bus.dcache_req  & ~bus.dcache_resp);
      load_use   = bus.ex_mem_read && (bus.ex_rd != '0) &&
                   ((bus.id_uses_rs1 && (bus.ex_rd == bus.id_rs1)) ||
                    (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
      ctrl       = '0;
      stall_inc  = 1'b0;
      bubble_inc = 1'b0;
      flush_inc  = 1'b0;
      if (reset) begin
         ctrl = '0;
      end else if (mem_stall) begin
         stall_inc = 1'b1;
      end else if (bus.ex_br_taken) begin
         ctrl      = '1;
         flush_inc = 1'b1;
      end else if (load_use) begin
         ctrl.id_ex_load  = 1'b1;
         ctrl.id_ex_flush = 1'b1;
         ctrl.ex_mem_load = 1'b1;
         ctrl.mem_wb_load = 1'b1;
         bubble_inc       = 1'b1;
      end else begin
         ctrl.pc_load     = 1'b1;
         ctrl.if_id_load  = 1'b1;
         ctrl.id_ex_load  = 1'b1;
         ctrl.ex_mem_load = 1'b1;
         ctrl.mem_wb_load = 1'b1;
      end
   end

   always_comb begin
      state_d         = mem_stall ? MEM_WAIT : RUN;
      run_cnt_d       = run_cnt_q;
      if (!mem_stall) begin
         run_cnt_d = '0;
      end else if (state_q == RUN) begin
         run_cnt_d = RUN_W'(1);
      end else if (run_cnt_q != RUN_W'(TIMEOUT)) begin
         run_cnt_d = run_cnt_q + RUN_W'(1);
      end
      stall_timeout_d = stall_timeout_q | (run_cnt_d == RUN_W'(TIMEOUT));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= RUN;
         run_cnt_q       <= '0;
         stall_timeout_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         run_cnt_q       <= run_cnt_d;
         stall_timeout_q <= stall_timeout_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk(clk), .reset(reset), .inc(stall_inc), .count(bus.stall_count)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk(clk), .reset(reset), .inc(bubble_inc), .count(bus.bubble_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk(clk), .reset(reset), .inc(flush_inc), .count(bus.flush_count)
   );

   assign bus.pc_load       = ctrl.pc_load;
   assign bus.if_id_load    = ctrl.if_id_load;
   assign bus.id_ex_load    = ctrl.id_ex_load;
   assign bus.ex_mem_load   = ctrl.ex_mem_load;
   assign bus.mem_wb_load   = ctrl.mem_wb_load;
   assign bus.if_id_flush   = ctrl.if_id_flush;
   assign bus.id_ex_flush   = ctrl.id_ex_flush;
   assign bus.stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random
// traffic, checked against a rule-level model of the hazard priorities.
module tb_hazard_stall_unit;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      int unsigned rs1, rs2, rd;
      bit uses1, uses2, mem_read, br;
      bit ic_read, ic_resp, dc_req, dc_resp;
   } stim_t;

   typedef struct {
      logic [6:0] ctrl;
      int         stall, bubble, flush;
      bit         tmo;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   exp_t sb[$];

   int m_stall = 0, m_bubble = 0, m_flush = 0, m_run = 0;
   bit m_tmo = 0;

   hazard_stall_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s.rs1 = 0; s.rs2 = 0; s.rd = 0;
      s.uses1 = 0; s.uses2 = 0; s.mem_read = 0; s.br = 0;
      s.ic_read = 0; s.ic_resp = 0; s.dc_req = 0; s.dc_resp = 0;
      return s;
   endfunction

   function automatic int sat_inc(int v);
      return (v >= CNT_MAX) ? CNT_MAX : v + 1;
   endfunction

   // Drive one cycle's inputs, record what the pipeline should see, advance model.
   task automatic applyStimulus(input stim_t s, input bit r);
      exp_t e;
      bit   frozen, hazard;
      @(posedge clk);
      #1;
      reset           = r;
      bus.id_rs1      = 5'(s.rs1);
      bus.id_rs2      = 5'(s.rs2);
      bus.ex_rd       = 5'(s.rd);
      bus.id_uses_rs1 = s.uses1;
      bus.id_uses_rs2 = s.uses2;
      bus.ex_mem_read = s.mem_read;
      bus.ex_br_taken = s.br;
      bus.icache_read = s.ic_read;
      bus.icache_resp = s.ic_resp;
      bus.dcache_req  = s.dc_req;
      bus.dcache_resp = s.dc_resp;

      frozen = (s.ic_read && !s.ic_resp) || (s.dc_req && !s.dc_resp);
      hazard = s.mem_read && s.rd != 0 &&
               ((s.uses1 && s.rd == s.rs1) || (s.uses2 && s.rd == s.rs2));

      if (r) begin
         m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_tmo = 0;
      end
      e.stall  = m_stall;
      e.bubble = m_bubble;
      e.flush  = m_flush;
      e.tmo    = m_tmo;
      if (r || frozen)   e.ctrl = 7'b00000_00;
      else if (s.br)     e.ctrl = 7'b11111_11;
      else if (hazard)   e.ctrl = 7'b00111_01;
      else               e.ctrl = 7'b11111_00;
      sb.push_back(e);

      if (!r) begin
         if (frozen)      m_stall  = sat_inc(m_stall);
         else if (s.br)   m_flush  = sat_inc(m_flush);
         else if (hazard) m_bubble = sat_inc(m_bubble);
         m_run = frozen ? m_run + 1 : 0;
         if (m_run >= TIMEOUT) m_tmo = 1;
      end
   endtask

   task automatic compareField(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      logic [6:0] act;
      act = {bus.pc_load, bus.if_id_load, bus.id_ex_load, bus.ex_mem_load,
             bus.mem_wb_load, bus.if_id_flush, bus.id_ex_flush};
      compareField("ctrl", int'(act), int'(e.ctrl));
      compareField("stall_count", int'(bus.stall_count), e.stall);
      compareField("bubble_count", int'(bus.bubble_count), e.bubble);
      compareField("flush_count", int'(bus.flush_count), e.flush);
      compareField("stall_timeout", int'(bus.stall_timeout), int'(e.tmo));
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         checkOutput(sb.pop_front());
      end
   end

   initial begin
      stim_t s;
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rd = '0;
      bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0; bus.ex_mem_read = 0;
      bus.ex_br_taken = 0; bus.icache_read = 0; bus.icache_resp = 0;
      bus.dcache_req = 0; bus.dcache_resp = 0;

      repeat (2) applyStimulus(idle(), 1);
      applyStimulus(idle(), 0);

      s = idle(); s.mem_read = 1; s.rd = 5; s.uses2 = 1; s.rs2 = 5;
      applyStimulus(s, 0);
      applyStimulus(idle(), 0);

      s = idle(); s.mem_read = 1; s.rd = 0; s.uses1 = 1; s.rs1 = 0;
      applyStimulus(s, 0);

      s = idle(); s.ic_read = 1;
      repeat (6) applyStimulus(s, 0);
      s.ic_resp = 1;
      applyStimulus(s, 0);
      applyStimulus(idle(), 0);

      s = idle(); s.br = 1; s.dc_req = 1;
      repeat (3) applyStimulus(s, 0);
      s.dc_resp = 1;
      applyStimulus(s, 0);
      applyStimulus(idle(), 0);

      s = idle(); s.br = 1; s.mem_read = 1; s.rd = 7; s.uses1 = 1; s.rs1 = 7;
      applyStimulus(s, 0);
      applyStimulus(idle(), 0);

      s = idle(); s.dc_req = 1;
      repeat (7) applyStimulus(s, 0);
      applyStimulus(idle(), 0);
      repeat (7) applyStimulus(s, 0);
      repeat (2) applyStimulus(idle(), 0);
      repeat (8) applyStimulus(s, 0);
      s.dc_resp = 1;
      applyStimulus(s, 0);
      repeat (2) applyStimulus(idle(), 0);

      s = idle(); s.ic_read = 1;
      repeat (3) applyStimulus(s, 0);
      applyStimulus(s, 1);
      applyStimulus(idle(), 0);

      s = idle(); s.mem_read = 1; s.rd = 9; s.uses1 = 1; s.rs1 = 9;
      repeat (20) applyStimulus(s, 0);
      applyStimulus(idle(), 0);

      applyStimulus(idle(), 1);
      for (int i = 0; i < 400; i++) begin
         s.rs1 = $urandom_range(0, 3);
         s.rs2 = $urandom_range(0, 3);
         s.rd  = $urandom_range(0, 3);
         s.uses1 = 1'($urandom_range(0, 1));
         s.uses2 = 1'($urandom_range(0, 1));
         s.mem_read = 1'($urandom_range(0, 1));
         s.br = ($urandom_range(0, 4) == 0);
         s.ic_read = ($urandom_range(0, 2) == 0);
         s.ic_resp = 1'($urandom_range(0, 1));
         s.dc_req  = ($urandom_range(0, 2) == 0);
         s.dc_resp = 1'($urandom_range(0, 1));
         applyStimulus(s, $urandom_range(0, 99) == 0);
      end

      repeat (3) @(posedge clk);
      compareField("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It handles the cases that operand forwarding into EX cannot cover:
- load-use: inserts a one-cycle bubble into ID/EX;
- cache-miss freeze: holds every pipeline register while the cache is busy;
- taken-branch flush: squashes IF/ID and ID/EX.

It sits beside the forwarding logic and drives the load and flush enables of the PC and of every stage register. It also keeps saturating performance counters and a sticky stall-timeout flag.

Parameters:
CNT_W, 32, width of each performance counter
TIMEOUT, 1024, number of consecutive memory-stall cycles before stall_timeout is set

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  the ID instruction reads rs1
id_uses_rs2  in  1  the ID instruction reads rs2
ex_mem_read  in  1  the instruction in EX is a load
ex_rd  in  5  destination register of the instruction in EX
ex_br_taken  in  1  control transfer resolved taken in EX (branch, jal, jalr)
icache_read  in  1  instruction fetch request outstanding
icache_resp  in  1  instruction cache response
dcache_req  in  1  MEM stage has a data read or write in flight
dcache_resp  in  1  data cache response
pc_load  out  1  PC register load enable
if_id_load  out  1  IF/ID load enable
id_ex_load  out  1  ID/EX load enable
ex_mem_load  out  1  EX/MEM load enable
mem_wb_load  out  1  MEM/WB load enable
if_id_flush  out  1  load a NOP into IF/ID
id_ex_flush  out  1  load a NOP into ID/EX
stall_count  out  CNT_W  number of cycles frozen by memory stalls
bubble_count  out  CNT_W  number of load-use bubbles inserted
flush_count  out  CNT_W  number of taken-branch flushes
stall_timeout  out  1  sticky flag, set after TIMEOUT consecutive memory-stall cycles

Behaviour:
- Internal stall terms:
  - mem_stall = (icache_read & ~icache_resp) | (dcache_req & ~dcache_resp)
  - load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2))
- State register, two states:
  - RUN -> MEM_WAIT when mem_stall = 1.
  - MEM_WAIT -> RUN on the first cycle with mem_stall = 0. That cycle is the advance cycle.
- Control outputs are combinational from the current inputs, applied in this priority order:
  1. reset high: all load and flush outputs = 0.
  2. mem_stall: all loads = 0, all flushes = 0. The pipeline is fully frozen. ex_br_taken and load_use are ignored this cycle and re-evaluated when the freeze ends, because EX and ID hold their contents.
  3. ex_br_taken: all loads = 1, if_id_flush = 1, id_ex_flush = 1. PC takes the target. Branch beats load-use because the ID instruction is on the wrong path.
  4. load_use: pc_load = 0, if_id_load = 0, id_ex_load = 1 with id_ex_flush = 1 (bubble), ex_mem_load = 1, mem_wb_load = 1.
  5. otherwise: all loads = 1, flushes = 0.
- At most one bubble per load. After the bubble, EX holds a NOP, so load_use deasserts and the MEM-to-EX forward supplies the data.
- Counters, all registered and saturating at all-ones (no wrap):
  - stall_count increments each cycle in which case 2 is active.
  - bubble_count increments each cycle in which case 4 is active.
  - flush_count increments each cycle in which case 3 is active.
- Timeout:
  - An internal run counter, width clog2(TIMEOUT+1), counts consecutive mem_stall cycles and clears on any cycle with mem_stall = 0.
  - When the run counter reaches TIMEOUT, stall_timeout is set. It clears only on reset.
- Reset (asynchronous, at any time including mid-stall):
  - state = RUN
  - all counters and the run counter = 0
  - stall_timeout = 0
  - control outputs = 0 while reset is held
- Register 0: ex_rd = 0 never causes a load-use stall.

Decomposition:
- Shared rv32i package holds:
  - the hazard_state_t enum (RUN, MEM_WAIT);
  - the register-index width constant (5);
  - the pipeline-control struct {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush}.
- One sub-module, sat_counter (parameter W, inputs inc and reset), instantiated three times.

Test Plan:
- Load-use on rs2: ex_mem_read=1, ex_rd=5, id_uses_rs2=1, id_rs2=5 for 1 cycle -> pc_load=0, if_id_load=0, id_ex_flush=1, ex_mem_load=1, mem_wb_load=1; bubble_count 0->1. ex_rd=0 with id_rs1=0 gives no stall.
- Icache miss: icache_read=1, icache_resp=0 for 6 cycles, then resp=1 -> all loads 0 for 6 cycles, loads 1 on cycle 7; stall_count=6.
- Branch during dcache miss: ex_br_taken=1 with dcache_req=1 and resp=0 for 3 cycles -> no flush during those 3 cycles; on the resp cycle if_id_flush=id_ex_flush=1 and flush_count=1.
- Branch plus load-use together: ex_br_taken=1 and load_use=1 -> flush case wins; bubble_count unchanged.
- Timeout with TIMEOUT=8: 8 consecutive mem_stall cycles -> stall_timeout=1 and stays 1 after resp; 7 stalls, a gap, then 7 more -> stays 0.
- Reset and saturation: reset asserted mid-stall -> counters 0, state RUN at once, all loads 0. With CNT_W=4, 20 bubbles -> bubble_count=15.
